// File: rtl/panel_bus_pkg.sv
// Shared panel write-bus defaults and arbiter state encodings.
package panel_bus_pkg;

  localparam int unsigned NUM_PANELS_DEF  = 9;
  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 24;
  localparam int unsigned CLEAR_WORDS_DEF = 4096;

  localparam logic [DATA_W_DEF-1:0] CLEAR_VALUE_DEF = '0;

  // One-hot arbiter/clear sequencer states.
  typedef enum logic [1:0] {
    ST_ARB   = 2'b01,
    ST_CLEAR = 2'b10
  } arb_state_t;

endpackage

// File: rtl/panel_rr_arb2.sv
// Two-way round-robin grant: picks the requester that did not win last time on a tie.
module panel_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_ready_c,
  output logic       o_grant_c
);

  // Grant selection; at most one ready bit is ever set.
  always_comb begin
    o_ready_c = 2'b00;
    o_grant_c = 1'b0;
    if (i_enable) begin
      if (&i_valid) begin
        o_grant_c = ~i_last_grant;
      end else begin
        o_grant_c = i_valid[1];
      end
      if (|i_valid) begin
        o_ready_c = o_grant_c ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: rtl/panel_write_arbiter.sv
// Shares the panel-RAM write bus between two writers and sweeps the panels on clear.
module panel_write_arbiter
  import panel_bus_pkg::*;
#(
  parameter int unsigned NUM_PANELS  = NUM_PANELS_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CLEAR_WORDS = CLEAR_WORDS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(CLEAR_VALUE_DEF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [NUM_PANELS-1:0] req0_en,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdat,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [NUM_PANELS-1:0] req1_en,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdat,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [NUM_PANELS-1:0] ctrl_en,
  output logic [ADDR_W-1:0]     ctrl_addr,
  output logic [DATA_W-1:0]     ctrl_wdat,
  output logic                  grant_id
);

  localparam int unsigned CNT_W = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_WORDS - 1);

  arb_state_t r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic r_last_grant, w_last_grant_next;
  logic r_final, w_final_next;
  logic [NUM_PANELS-1:0] w_en_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_wdat_next;
  logic w_gid_next;
  logic [1:0] w_ready;
  logic w_grant;

  panel_rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (r_state == ST_ARB),
    .o_ready_c    (w_ready),
    .o_grant_c    (w_grant)
  );

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

  // Next-state, clear counter and next bus word.
  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_last_grant_next = r_last_grant;
    w_final_next      = 1'b0;
    w_en_next         = '0;
    w_addr_next       = ctrl_addr;
    w_wdat_next       = ctrl_wdat;
    w_gid_next        = grant_id;
    case (r_state)
      ST_ARB: begin
        if (|w_ready) begin
          w_last_grant_next = w_grant;
          w_gid_next        = w_grant;
          w_en_next         = w_grant ? req1_en   : req0_en;
          w_addr_next       = w_grant ? req1_addr : req0_addr;
          w_wdat_next       = w_grant ? req1_wdat : req0_wdat;
        end
        if (clear_start) begin
          w_state_next = ST_CLEAR;
          w_count_next = '0;
        end
      end
      ST_CLEAR: begin
        w_en_next   = '1;
        w_addr_next = ADDR_W'(r_count);
        w_wdat_next = CLEAR_VALUE;
        if (r_count == CNT_LAST) begin
          w_state_next = ST_ARB;
          w_final_next = 1'b1;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_ARB;
      end
    endcase
  end

  // State, counter and registered bus outputs; busy tracks clear words on the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_ARB;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_final      <= 1'b0;
      ctrl_en      <= '0;
      ctrl_addr    <= '0;
      ctrl_wdat    <= '0;
      grant_id     <= 1'b0;
      clear_busy   <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_last_grant <= w_last_grant_next;
      r_final      <= w_final_next;
      ctrl_en      <= w_en_next;
      ctrl_addr    <= w_addr_next;
      ctrl_wdat    <= w_wdat_next;
      grant_id     <= w_gid_next;
      clear_busy   <= (r_state == ST_CLEAR);
      clear_done   <= r_final;
    end
  end

endmodule

// File: tb/tb_panel_write_arbiter.sv
// Directed bench for panel_write_arbiter: arbitration, no-op writes, clear sequencing, reset abort.
module tb_panel_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [8:0]  req0_en, req1_en;
  logic [15:0] req0_addr, req1_addr;
  logic [23:0] req0_wdat, req1_wdat;
  logic        clear_start, clear_busy, clear_done;
  logic [8:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        grant_id;

  int n_cmp = 0;
  int n_err = 0;

  panel_write_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_en     (req0_en),
    .req0_addr   (req0_addr),
    .req0_wdat   (req0_wdat),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_en     (req1_en),
    .req1_addr   (req1_addr),
    .req1_wdat   (req1_wdat),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .ctrl_en     (ctrl_en),
    .ctrl_addr   (ctrl_addr),
    .ctrl_wdat   (ctrl_wdat),
    .grant_id    (grant_id)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_en = '0; req0_addr = '0; req0_wdat = '0;
    req1_en = '0; req1_addr = '0; req1_wdat = '0;
    do_reset();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, ctrl_wdat, clear_busy, clear_done, grant_id, req0_ready, req1_ready}
        !== {9'h0, 16'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: en=%h addr=%h wdat=%h busy=%b done=%b gid=%b rdy=%b%b expected all zero",
               ctrl_en, ctrl_addr, ctrl_wdat, clear_busy, clear_done, grant_id, req1_ready, req0_ready);
    end
  endtask

  // Both requesters valid from reset: grants alternate starting with 0.
  task automatic test_alternate();
    logic exp_g;
    do_reset();
    req0_valid = 1; req0_en = 9'h001; req0_addr = 16'h00A0; req0_wdat = 24'hA00000;
    req1_valid = 1; req1_en = 9'h100; req1_addr = 16'h00B0; req1_wdat = 24'hB00000;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2) == 1;
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL alt_ready[%0d]: got %b%b expected %b", i, req1_ready, req0_ready,
                 exp_g ? 2'b10 : 2'b01);
      end
      tick();
      n_cmp++;
      if ({grant_id, ctrl_en, ctrl_addr, ctrl_wdat} !==
          (exp_g ? {1'b1, 9'h100, 16'h00B0, 24'hB00000} : {1'b0, 9'h001, 16'h00A0, 24'hA00000})) begin
        n_err++;
        $display("FAIL alt_write[%0d]: gid=%b en=%h addr=%h wdat=%h expected gid=%b", i,
                 grant_id, ctrl_en, ctrl_addr, ctrl_wdat, exp_g);
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  // Only requester 0 active: four writes, one-cycle lag, then bus idles with held address.
  task automatic test_single_req0();
    n_cmp++;
    if (ctrl_en !== 9'h0) begin
      n_err++;
      $display("FAIL single_idle: en=%h expected 000", ctrl_en);
    end
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_en = 9'h003; req0_addr = 16'(i); req0_wdat = 24'h000100 + 24'(i);
      #1;
      n_cmp++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL single_ready[%0d]: got %b%b expected 01", i, req1_ready, req0_ready);
      end
      tick();
      n_cmp++;
      if ({grant_id, ctrl_en, ctrl_addr, ctrl_wdat} !== {1'b0, 9'h003, 16'(i), 24'h000100 + 24'(i)}) begin
        n_err++;
        $display("FAIL single_write[%0d]: gid=%b en=%h addr=%h wdat=%h expected addr=%h", i,
                 grant_id, ctrl_en, ctrl_addr, ctrl_wdat, 16'(i));
      end
    end
    req0_valid = 0;
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, ctrl_wdat} !== {9'h0, 16'h0003, 24'h000103}) begin
      n_err++;
      $display("FAIL single_hold: en=%h addr=%h wdat=%h expected en=000 addr=0003 wdat=000103",
               ctrl_en, ctrl_addr, ctrl_wdat);
    end
  endtask

  // Valid with en==0 is still accepted and passes through as a no-op write.
  task automatic test_noop_write();
    req1_valid = 1; req1_en = 9'h0; req1_addr = 16'h1234; req1_wdat = 24'h555555;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL noop_ready: got %b%b expected 10", req1_ready, req0_ready);
    end
    tick();
    req1_valid = 0;
    n_cmp++;
    if ({grant_id, ctrl_en, ctrl_addr, ctrl_wdat} !== {1'b1, 9'h0, 16'h1234, 24'h555555}) begin
      n_err++;
      $display("FAIL noop_write: gid=%b en=%h addr=%h wdat=%h expected gid=1 en=000 addr=1234 wdat=555555",
               grant_id, ctrl_en, ctrl_addr, ctrl_wdat);
    end
    tick();
  endtask

  // Clear with same-cycle req1 grant; req0 held during clear gets written once afterwards.
  task automatic test_clear_with_req();
    int bad;
    req1_valid = 1; req1_en = 9'h0F0; req1_addr = 16'h0777; req1_wdat = 24'h777777;
    clear_start = 1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL clr_req1_ready: got %b%b expected 10", req1_ready, req0_ready);
    end
    tick();
    clear_start = 0; req1_valid = 0;
    n_cmp++;
    if ({grant_id, ctrl_en, ctrl_addr, ctrl_wdat, clear_busy} !== {1'b1, 9'h0F0, 16'h0777, 24'h777777, 1'b0}) begin
      n_err++;
      $display("FAIL clr_req1_write: gid=%b en=%h addr=%h wdat=%h busy=%b expected gid=1 en=0f0 addr=0777",
               grant_id, ctrl_en, ctrl_addr, ctrl_wdat, clear_busy);
    end
    req0_valid = 1; req0_en = 9'h011; req0_addr = 16'h0ABC; req0_wdat = 24'h123456;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL clr_ready_first: got %b%b expected 00", req1_ready, req0_ready);
    end
    bad = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      n_cmp++;
      if ({ctrl_en, ctrl_addr, ctrl_wdat, clear_busy, clear_done} !== {9'h1FF, 16'(k), 24'h0, 1'b1, 1'b0}) begin
        n_err++;
        if (bad < 8) $display("FAIL clr_word[%0d]: en=%h addr=%h wdat=%h busy=%b done=%b", k,
                              ctrl_en, ctrl_addr, ctrl_wdat, clear_busy, clear_done);
        bad++;
      end
      if (k < 4095) begin
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
          n_err++;
          if (bad < 8) $display("FAIL clr_ready[%0d]: got %b%b expected 00", k, req1_ready, req0_ready);
          bad++;
        end
      end
    end
    tick();
    req0_valid = 0;
    n_cmp++;
    if ({clear_done, clear_busy, grant_id, ctrl_en, ctrl_addr, ctrl_wdat} !==
        {1'b1, 1'b0, 1'b0, 9'h011, 16'h0ABC, 24'h123456}) begin
      n_err++;
      $display("FAIL clr_done_req0: done=%b busy=%b gid=%b en=%h addr=%h wdat=%h expected 1 0 0 011 0abc 123456",
               clear_done, clear_busy, grant_id, ctrl_en, ctrl_addr, ctrl_wdat);
    end
    tick();
    n_cmp++;
    if ({clear_done, clear_busy, ctrl_en} !== {1'b0, 1'b0, 9'h0}) begin
      n_err++;
      $display("FAIL clr_after: done=%b busy=%b en=%h expected 0 0 000", clear_done, clear_busy, ctrl_en);
    end
  endtask

  // clear_start re-pulsed mid-clear is ignored: still exactly 4096 writes, no restart.
  task automatic test_clear_repulse();
    int bad;
    clear_start = 1;
    tick();
    clear_start = 0;
    bad = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      clear_start = (k == 99);
      n_cmp++;
      if ({ctrl_en, ctrl_addr, clear_busy, clear_done} !== {9'h1FF, 16'(k), 1'b1, 1'b0}) begin
        n_err++;
        if (bad < 8) $display("FAIL rep_word[%0d]: en=%h addr=%h busy=%b done=%b", k,
                              ctrl_en, ctrl_addr, clear_busy, clear_done);
        bad++;
      end
    end
    clear_start = 0;
    tick();
    n_cmp++;
    if ({clear_done, clear_busy, ctrl_en} !== {1'b1, 1'b0, 9'h0}) begin
      n_err++;
      $display("FAIL rep_done: done=%b busy=%b en=%h expected 1 0 000", clear_done, clear_busy, ctrl_en);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if ({clear_done, clear_busy, ctrl_en} !== {1'b0, 1'b0, 9'h0}) begin
        n_err++;
        $display("FAIL rep_idle[%0d]: done=%b busy=%b en=%h expected 0 0 000", j,
                 clear_done, clear_busy, ctrl_en);
      end
    end
  endtask

  // Reset at count 2000 aborts the clear; a new clear starts again at address 0.
  task automatic test_reset_mid_clear();
    clear_start = 1;
    tick();
    clear_start = 0;
    for (int k = 0; k < 2000; k++) tick();
    n_cmp++;
    if ({ctrl_addr, clear_busy} !== {16'd1999, 1'b1}) begin
      n_err++;
      $display("FAIL rst_pre: addr=%0d busy=%b expected 1999 1", ctrl_addr, clear_busy);
    end
    reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if ({ctrl_en, ctrl_addr, ctrl_wdat, clear_busy, clear_done, grant_id} !== {9'h0, 16'h0, 24'h0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_abort: en=%h addr=%h busy=%b done=%b gid=%b expected all zero",
               ctrl_en, ctrl_addr, clear_busy, clear_done, grant_id);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      n_cmp++;
      if ({clear_done, clear_busy, ctrl_en} !== {1'b0, 1'b0, 9'h0}) begin
        n_err++;
        $display("FAIL rst_quiet[%0d]: done=%b busy=%b en=%h expected 0 0 000", j,
                 clear_done, clear_busy, ctrl_en);
      end
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_last_grant: got %b%b expected 01", req1_ready, req0_ready);
    end
    req0_valid = 0; req1_valid = 0;
    clear_start = 1;
    tick();
    clear_start = 0;
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, clear_busy} !== {9'h1FF, 16'h0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_restart0: en=%h addr=%h busy=%b expected 1ff 0000 1", ctrl_en, ctrl_addr, clear_busy);
    end
    tick();
    n_cmp++;
    if ({ctrl_en, ctrl_addr, clear_busy} !== {9'h1FF, 16'h1, 1'b1}) begin
      n_err++;
      $display("FAIL rst_restart1: en=%h addr=%h busy=%b expected 1ff 0001 1", ctrl_en, ctrl_addr, clear_busy);
    end
    do_reset();
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_alternate();
    test_single_req0();
    test_noop_write();
    test_clear_with_req();
    test_clear_repulse();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
